// File: rtl/fp_packer.sv
// Packs a normalized-or-not significand product into an IEEE-754 word:
// multi-cycle normalization, round-to-nearest-even, range clamping and special values.
`timescale 1ns/1ps
module fp_packer #(
    parameter int IS_DOUBLE  = 0,
    parameter int WIDTH      = IS_DOUBLE ? 64 : 32,
    parameter int EXPONENT_W = IS_DOUBLE ? 11 : 8,
    parameter int MANTISSA_W = IS_DOUBLE ? 52 : 23
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sign,
    input  logic signed [EXPONENT_W+1:0]   in_exp,
    input  logic        [2*MANTISSA_W+1:0] in_mant,
    input  logic                           in_nan,
    input  logic                           in_inf,
    input  logic                           in_zero,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic        [WIDTH-1:0]        out_res,
    output logic        [1:0]              fsm_state
);
    localparam int P = 2*MANTISSA_W+2;
    localparam int E = EXPONENT_W+2;

    localparam logic signed [E-1:0] EXP_ONE = {{(E-1){1'b0}}, 1'b1};
    localparam logic signed [E-1:0] EXP_MAX = {1'b0, {(E-1){1'b1}}};
    localparam logic signed [E-1:0] EXP_MIN = {1'b1, {(E-1){1'b0}}};
    localparam logic signed [E-1:0] EXP_INF = {2'b00, {EXPONENT_W{1'b1}}};

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the payload is held stable while valid waits.
    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, OUT = 2'd3} state_t;

    state_t                 state, state_next;
    logic                   sign_r, sign_next;
    logic signed [E-1:0]    exp_r, exp_next;
    logic        [P-1:0]    mant_r, mant_next;
    logic                   sticky_r, sticky_next;
    logic        [WIDTH-1:0] res_r, res_next;

    logic                   special;
    logic [MANTISSA_W-1:0]  frac;
    logic                   guard;
    logic                   low_sticky;
    logic                   round_up;
    logic [MANTISSA_W:0]    frac_sum;
    logic signed [E-1:0]    exp_rnd;
    logic [WIDTH-1:0]       round_res;
    logic [WIDTH-1:0]       special_res;

    // Exponent moves saturate so extreme inputs clamp instead of wrapping sign.
    function automatic logic signed [E-1:0] exp_inc(input logic signed [E-1:0] x);
        return (x == EXP_MAX) ? x : x + EXP_ONE;
    endfunction

    function automatic logic signed [E-1:0] exp_dec(input logic signed [E-1:0] x);
        return (x == EXP_MIN) ? x : x - EXP_ONE;
    endfunction

    assign special = in_nan | in_inf | in_zero;

    always_comb begin
        if (in_nan)
            special_res = {1'b0, {EXPONENT_W{1'b1}}, 1'b1, {(MANTISSA_W-1){1'b0}}};
        else if (in_inf)
            special_res = {in_sign, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
        else
            special_res = {in_sign, {(WIDTH-1){1'b0}}};
    end

    always_comb begin
        frac       = mant_r[P-3 -: MANTISSA_W];
        guard      = mant_r[P-3-MANTISSA_W];
        low_sticky = (|mant_r[P-4-MANTISSA_W:0]) | sticky_r;
        round_up   = guard & (low_sticky | frac[0]);
        frac_sum   = {1'b0, frac} + {{MANTISSA_W{1'b0}}, round_up};
        exp_rnd    = frac_sum[MANTISSA_W] ? exp_inc(exp_r) : exp_r;
        if (exp_rnd >= EXP_INF)
            round_res = {sign_r, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
        else if (exp_rnd[E-1] || exp_rnd == '0)
            round_res = {sign_r, {(WIDTH-1){1'b0}}};
        else
            round_res = {sign_r, exp_rnd[EXPONENT_W-1:0], frac_sum[MANTISSA_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (in_valid) state_next = special ? OUT : NORM;
            NORM: begin
                if (mant_r[P-1] || mant_r[P-2]) state_next = ROUND;
                else if (mant_r == '0)          state_next = OUT;
                else                            state_next = NORM;
            end
            ROUND: state_next = OUT;
            OUT:   if (out_ready) state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) & ~rst;
        out_valid = (state == OUT);
        out_res   = res_r;
        fsm_state = state;
    end

    always_comb begin
        sign_next   = sign_r;
        exp_next    = exp_r;
        mant_next   = mant_r;
        sticky_next = sticky_r;
        res_next    = res_r;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_next   = in_sign;
                    exp_next    = in_exp;
                    mant_next   = in_mant;
                    sticky_next = 1'b0;
                    res_next    = special ? special_res : '0;
                end
            end
            NORM: begin
                if (mant_r[P-1]) begin
                    mant_next   = mant_r >> 1;
                    sticky_next = sticky_r | mant_r[0];
                    exp_next    = exp_inc(exp_r);
                end else if (mant_r[P-2]) begin
                    mant_next = mant_r;
                end else if (mant_r == '0) begin
                    res_next = {sign_r, {(WIDTH-1){1'b0}}};
                end else begin
                    mant_next = mant_r << 1;
                    exp_next  = exp_dec(exp_r);
                end
            end
            ROUND: res_next = round_res;
            OUT:   res_next = res_r;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            sticky_r <= 1'b0;
            res_r    <= '0;
        end else begin
            sign_r   <= sign_next;
            exp_r    <= exp_next;
            mant_r   <= mant_next;
            sticky_r <= sticky_next;
            res_r    <= res_next;
        end
    end

endmodule

// File: tb/tb_fp_packer.sv
// Bench for fp_packer (binary32): directed vector table, handshake/reset sequences,
// and random operands checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fp_packer;
    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic signed [9:0]  in_exp;
    logic [47:0]        in_mant;
    logic               in_nan, in_inf, in_zero;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_res;
    logic [1:0]         fsm_state;

    int total = 0;
    int bad   = 0;

    fp_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              s;
        logic signed [9:0] e;
        logic [47:0]       m;
        logic              fn, fi, fz;
        logic [31:0]       res;
        int                lat;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                        input logic fn, input logic fi, input logic fz);
        int wait_cnt;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("ready_before_send", in_ready, 1);
        in_sign = s; in_exp = e; in_mant = m;
        in_nan = fn; in_inf = fi; in_zero = fz;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the acceptance edge until out_valid; -1 on timeout.
    task automatic wait_out(output logic [31:0] res, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_res;
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                         input logic fn, input logic fi, input logic fz,
                         output logic [31:0] res, output int lat);
        send(s, e, m, fn, fi, fz);
        wait_out(res, lat);
        release_out();
    endtask

    // Reference: locate the leading one, align, round on the integer remainder.
    function automatic void ref_model(input logic s, input int e, input logic [47:0] m,
                                      input logic fn, input logic fi, input logic fz,
                                      output logic [31:0] res, output int lat);
        longint unsigned a, sig, rem, half;
        int ex, k, sh;
        lat = 0;
        if (fn)          res = 32'h7FC00000;
        else if (fi)     res = {s, 8'hFF, 23'h0};
        else if (fz)     res = {s, 31'h0};
        else if (m == 0) begin
            res = {s, 31'h0};
            lat = 1;
        end else begin
            k = 0;
            for (int i = 0; i < 48; i++) if (m[i]) k = i;
            a = 64'(m);
            if (k == 47) begin
                sig = a >> 24; rem = a & 64'hFFFFFF; half = 64'h800000;
                ex = e + 1; lat = 2;
            end else begin
                sh = 46 - k;
                a = a << sh;
                sig = a >> 23; rem = a & 64'h7FFFFF; half = 64'h400000;
                ex = e - sh; lat = 2 + sh;
            end
            if (rem > half || (rem == half && sig[0])) sig++;
            if (sig == 64'h1000000) begin
                sig = sig >> 1;
                ex++;
            end
            if (ex >= 255)     res = {s, 8'hFF, 23'h0};
            else if (ex <= 0)  res = {s, 31'h0};
            else               res = {s, 8'(ex), sig[22:0]};
        end
    endfunction

    initial begin
        logic [31:0] r, exp_r;
        int          l, exp_l, seen, e_int, sel;
        logic [47:0] m;
        logic        s, fn, fi, fz;

        tbl[0]  = '{1'b0,  10'sd127, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 2};
        tbl[1]  = '{1'b0,  10'sd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 2};
        tbl[2]  = '{1'b0,  10'sd129, 48'h100000000000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4};
        tbl[3]  = '{1'b0,  10'sd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 2};
        tbl[4]  = '{1'b0,  10'sd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 2};
        tbl[5]  = '{1'b0,  10'sd255, 48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 2};
        tbl[6]  = '{1'b1,  10'sd0,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 2};
        tbl[7]  = '{1'b1,  10'sd50,  48'h400000000000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 0};
        tbl[8]  = '{1'b1,  10'sd50,  48'h400000000000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 0};
        tbl[9]  = '{1'b1,  10'sd50,  48'h400000000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 0};
        tbl[10] = '{1'b1,  10'sd50,  48'h400000000000, 1'b1, 1'b1, 1'b1, 32'h7FC00000, 0};
        tbl[11] = '{1'b0,  10'sd50,  48'h400000000000, 1'b0, 1'b1, 1'b1, 32'h7F800000, 0};
        tbl[12] = '{1'b1,  10'sd100, 48'h000000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1};
        tbl[13] = '{1'b0,  10'sd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h40000000, 2};
        tbl[14] = '{1'b0,  10'sd127, 48'h800000800001, 1'b0, 1'b0, 1'b0, 32'h40000001, 2};
        tbl[15] = '{1'b0,  10'sd1,   48'h200000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 3};
        tbl[16] = '{1'b0,  10'sd254, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 2};
        tbl[17] = '{1'b0, -10'sd512, 48'h000000000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 48};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_state", fsm_state, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 18; i++) begin
            do_op(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].fn, tbl[i].fi, tbl[i].fz, r, l);
            chk($sformatf("vec%0d_res", i), r, tbl[i].res);
            chk($sformatf("vec%0d_lat", i), l, tbl[i].lat);
        end

        // Stall in OUT with a competing operand waiting upstream.
        send(1'b0, 10'sd127, 48'h400000000000, 1'b0, 1'b0, 1'b0);
        wait_out(r, l);
        chk("stall_first_res", r, 32'h3F800000);
        @(negedge clk);
        in_mant = 48'h900000000000; in_exp = 10'sd127; in_sign = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_res", out_res, 32'h3F800000);
            chk("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_no_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("next_cycle_accept", in_ready, 0);
        wait_out(r, l);
        chk("queued_res", r, 32'h40100000);
        chk("queued_lat", l, 2);
        release_out();

        // Reset while the operand is still shifting in NORM.
        send(1'b0, 10'sd100, 48'h000000000001, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("midop_state_norm", fsm_state, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_res", out_res, 0);
        chk("midrst_state", fsm_state, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_valid", out_valid, 0);
        chk("after_rst_in_ready", in_ready, 1);
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_stale_result", seen, 0);

        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       e_int = int'($urandom_range(0, 1023)) - 512;
                1:       e_int = int'($urandom_range(100, 160));
                2:       e_int = int'($urandom_range(0, 30)) - 10;
                default: e_int = int'($urandom_range(240, 270));
            endcase
            m = 48'({$urandom(), $urandom()});
            m = (m | 48'h800000000000) >> $urandom_range(0, 47);
            if ($urandom_range(0, 3) == 0) m = (m & ~48'h3FFFFF) | 48'h400000;
            if ($urandom_range(0, 15) == 0) m = '0;
            s  = 1'($urandom_range(0, 1));
            fn = ($urandom_range(0, 7) == 0);
            fi = ($urandom_range(0, 7) == 0);
            fz = ($urandom_range(0, 7) == 0);
            ref_model(s, e_int, m, fn, fi, fz, exp_r, exp_l);
            do_op(s, 10'(e_int), m, fn, fi, fz, r, l);
            chk($sformatf("rnd%0d_res", n), r, exp_r);
            chk($sformatf("rnd%0d_lat", n), l, exp_l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
